// File: rtl/mnist_pkg.sv
// Shared constants, frame geometry derivation and FSM state type for the
// MNIST input packer.
package mnist_pkg;

  localparam int unsigned PIXEL_W_DEF      = 8;
  localparam int unsigned PIX_PER_BEAT_DEF = 4;
  localparam int unsigned N_PIXELS_DEF     = 784;
  localparam int unsigned IN_BITS_DEF      = 1;
  localparam int unsigned BEATS_DEF        = N_PIXELS_DEF / PIX_PER_BEAT_DEF;

  // Beat counter width; a single-beat frame still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/mnist_input_packer_if.sv
// Valid/ready stream bundle used for both the pixel input and the packed frame output.
interface mnist_input_packer_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              valid;
  logic              ready;
  logic              last;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/px_quant.sv
// Combinational pixel quantizer: keeps the IN_BITS most significant bits of a pixel.
module px_quant
  import mnist_pkg::*;
#(
  parameter int unsigned PIXEL_W = PIXEL_W_DEF,
  parameter int unsigned IN_BITS = IN_BITS_DEF
) (
  input  logic [PIXEL_W-1:0] i_px,
  output logic [IN_BITS-1:0] o_q
);

  // Truncating shift, no rounding.
  assign o_q = IN_BITS'(i_px >> (PIXEL_W - IN_BITS));

endmodule

// File: rtl/mnist_input_packer.sv
// MNIST input packer: quantizes PIX_PER_BEAT pixels per beat and assembles a full
// frame for the layer-0 LUT neurons, holding it under valid/ready until taken.
// Optional build macro: INPUT_PACKER_LAST_CHECK_EN enables s_last framing checks
// and the err pulse; without it s_last is ignored and err stays low.
module mnist_input_packer
  import mnist_pkg::*;
#(
  parameter int unsigned PIXEL_W      = PIXEL_W_DEF,
  parameter int unsigned PIX_PER_BEAT = PIX_PER_BEAT_DEF,
  parameter int unsigned N_PIXELS     = N_PIXELS_DEF,
  parameter int unsigned IN_BITS      = IN_BITS_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mnist_input_packer_if.slave   s_if,
  mnist_input_packer_if.master  m_if,
  output logic [15:0]           o_frame_cnt,
  output logic                  o_err
);

  localparam int unsigned BEATS = N_PIXELS / PIX_PER_BEAT;
  localparam int unsigned CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e                    r_state, w_state_d;
  logic [CNT_W-1:0]          r_cnt, w_cnt_d;
  logic [15:0]               r_frame_cnt, w_frame_cnt_d;
  logic                      r_err, w_err_d;
  logic [N_PIXELS*IN_BITS-1:0] r_data;
  logic [IN_BITS-1:0]        w_q [PIX_PER_BEAT];
  logic                      w_accept;
  logic                      w_last_beat;
  logic                      w_mismatch;

  for (genvar j = 0; j < PIX_PER_BEAT; j++) begin : g_lane
    px_quant #(
      .PIXEL_W (PIXEL_W),
      .IN_BITS (IN_BITS)
    ) u_px_quant (
      .i_px (s_if.data[j*PIXEL_W +: PIXEL_W]),
      .o_q  (w_q[j])
    );
  end

  assign w_accept    = s_if.valid && (r_state == FILL);
  assign w_last_beat = (r_cnt == LAST_BEAT);

`ifdef INPUT_PACKER_LAST_CHECK_EN
  assign w_mismatch = w_accept && (s_if.last != w_last_beat);
`else
  assign w_mismatch = 1'b0;
`endif

  // Next-state logic for the fill/hold FSM, beat counter, frame counter and error pulse.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_frame_cnt_d = r_frame_cnt;
    w_err_d       = 1'b0;
    unique case (r_state)
      FILL: begin
        if (w_accept) begin
          if (w_mismatch) begin
            // Drop the frame; the next beat restarts at pixel 0.
            w_cnt_d = '0;
            w_err_d = 1'b1;
          end else if (w_last_beat) begin
            w_state_d = HOLD;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (m_if.ready) begin
          w_state_d     = FILL;
          w_frame_cnt_d = r_frame_cnt + 16'd1;
        end
      end
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_frame_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_frame_cnt <= w_frame_cnt_d;
      r_err       <= w_err_d;
    end
  end

  // Frame buffer: each accepted beat writes its lanes into the slots selected by the counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (w_accept) begin
      for (int j = 0; j < int'(PIX_PER_BEAT); j++) begin
        r_data[(int'(r_cnt) * int'(PIX_PER_BEAT) + j) * int'(IN_BITS) +: IN_BITS] <= w_q[j];
      end
    end
  end

  assign s_if.ready  = (r_state == FILL);
  assign m_if.valid  = (r_state == HOLD);
  assign m_if.data   = r_data;
  assign m_if.last   = 1'b1;  // whole frame is a single output transfer
  assign o_frame_cnt = r_frame_cnt;
  assign o_err       = r_err;

endmodule

// File: tb/tb_mnist_input_packer.sv
// Self-checking bench for mnist_input_packer: directed sequence with random pixel
// data and input gaps, expected frames computed from the pixel array in the bench.
module tb_mnist_input_packer;
  import mnist_pkg::*;

  localparam int unsigned PW  = PIXEL_W_DEF;
  localparam int unsigned PPB = PIX_PER_BEAT_DEF;
  localparam int unsigned NP  = N_PIXELS_DEF;
  localparam int unsigned IB  = IN_BITS_DEF;
  localparam int unsigned NB  = NP / PPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] frame_cnt;
  logic        err;

  always #5 clk = ~clk;

  mnist_input_packer_if #(.DATA_W(PPB*PW)) s_if ();
  mnist_input_packer_if #(.DATA_W(NP*IB))  m_if ();

  mnist_input_packer #(
    .PIXEL_W      (PW),
    .PIX_PER_BEAT (PPB),
    .N_PIXELS     (NP),
    .IN_BITS      (IB)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .s_if        (s_if),
    .m_if        (m_if),
    .o_frame_cnt (frame_cnt),
    .o_err       (err)
  );

  int unsigned         checks = 0;
  int unsigned         errors = 0;
  logic [PW-1:0]       pix [NP];
  logic [NP*IB-1:0]    exp_data;
  logic [15:0]         exp_fc = '0;

  // Reference: pixel p quantized to its top IB bits lands at slot p.
  function automatic logic [NP*IB-1:0] model_frame();
    logic [NP*IB-1:0] v;
    v = '0;
    for (int p = 0; p < int'(NP); p++) v[p*IB +: IB] = IB'(pix[p] >> (PW - IB));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_data(input string tag, input logic [NP*IB-1:0] obs,
                          input logic [NP*IB-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // mode 0: all 0xFF, mode 1: pixel p = p[7:0], otherwise random.
  task automatic fill_pix(input int mode);
    for (int p = 0; p < int'(NP); p++) begin
      if (mode == 0)      pix[p] = '1;
      else if (mode == 1) pix[p] = PW'(p);
      else                pix[p] = PW'($urandom);
    end
  endtask

  // Drive beats k0..k1-1 of pix, s_last on beat last_at, random idle gaps of gap_pct %.
  task automatic send_beats(input int k0, input int k1, input int last_at, input int gap_pct);
    logic acc;
    int   t;
    for (int k = k0; k < k1; k++) begin
      while ((gap_pct > 0) && ($urandom_range(99) < gap_pct)) begin
        s_if.valid = 1'b0;
        @(posedge clk); #1;
      end
      s_if.valid = 1'b1;
      s_if.last  = (k == last_at);
      for (int j = 0; j < int'(PPB); j++) s_if.data[j*PW +: PW] = pix[k*PPB + j];
      t = 0;
      do begin
        acc = s_if.ready;
        @(posedge clk); #1;
        t++;
      end while (!acc && t < 1000);
      if (!acc) chk("beat_accept_timeout", {31'd0, acc}, 32'd1);
    end
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic handshake();
    m_if.ready = 1'b1;
    @(posedge clk); #1;
    m_if.ready = 1'b0;
    exp_fc++;
    chk("hs_m_valid_low", {31'd0, m_if.valid}, 32'd0);
    chk("hs_s_ready_high", {31'd0, s_if.ready}, 32'd1);
    chk("hs_frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fc});
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_fc = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    s_if.data  = '0;
    m_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_s_ready", {31'd0, s_if.ready}, 32'd1);
    chk("rst_m_valid", {31'd0, m_if.valid}, 32'd0);
    chk_data("rst_m_data", m_if.data, '0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // All-0xFF frame back-to-back with m_ready held high from the start
    fill_pix(0);
    m_if.ready = 1'b1;
    send_beats(0, NB - 1, NB - 1, 0);
    chk("ff_m_valid_before_last", {31'd0, m_if.valid}, 32'd0);
    chk("ff_frame_cnt_ignored", {16'd0, frame_cnt}, 32'd0);
    send_beats(NB - 1, NB, NB - 1, 0);
    chk("ff_m_valid", {31'd0, m_if.valid}, 32'd1);
    chk("ff_s_ready", {31'd0, s_if.ready}, 32'd0);
    chk_data("ff_m_data", m_if.data, '1);
    @(posedge clk); #1;
    m_if.ready = 1'b0;
    exp_fc = 16'd1;
    chk("ff_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("ff_s_ready_after", {31'd0, s_if.ready}, 32'd1);
    chk("ff_m_valid_after", {31'd0, m_if.valid}, 32'd0);

    // Ramp frame: pixel p = p[7:0]
    fill_pix(1);
    send_beats(0, NB, NB - 1, 0);
    exp_data = model_frame();
    chk("ramp_m_valid", {31'd0, m_if.valid}, 32'd1);
    chk_data("ramp_m_data", m_if.data, exp_data);
    chk("ramp_bit127", {31'd0, m_if.data[127]}, 32'd0);
    chk("ramp_bit128", {31'd0, m_if.data[128]}, 32'd1);
    chk("ramp_bit767", {31'd0, m_if.data[767]}, 32'd1);
    chk("ramp_bit768", {31'd0, m_if.data[768]}, 32'd0);
    handshake();

    // Random data with input gaps, then 20 stalled cycles in hold
    fill_pix(2);
    send_beats(0, NB, NB - 1, 30);
    exp_data = model_frame();
    for (int c = 0; c < 20; c++) begin
      s_if.valid = 1'b1;
      s_if.data  = PPB*PW'($urandom);
      @(posedge clk); #1;
      chk("hold_s_ready", {31'd0, s_if.ready}, 32'd0);
      chk("hold_m_valid", {31'd0, m_if.valid}, 32'd1);
      chk_data("hold_m_data", m_if.data, exp_data);
    end
    s_if.valid = 1'b0;
    chk("hold_frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fc});
    handshake();
    fill_pix(2);
    send_beats(0, NB, NB - 1, 50);
    chk_data("gap2_m_data", m_if.data, model_frame());
    handshake();

    // Reset after 100 beats discards the partial frame
    fill_pix(2);
    send_beats(0, 100, -1, 0);
    pulse_reset();
    chk("midrst_m_valid", {31'd0, m_if.valid}, 32'd0);
    chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("midrst_s_ready", {31'd0, s_if.ready}, 32'd1);
    chk_data("midrst_m_data", m_if.data, '0);
    fill_pix(2);
    send_beats(0, NB, NB - 1, 10);
    chk("fresh_m_valid", {31'd0, m_if.valid}, 32'd1);
    chk_data("fresh_m_data", m_if.data, model_frame());
    chk("fresh_err", {31'd0, err}, 32'd0);
    handshake();

    // Early s_last on beat 50
    pulse_reset();
    fill_pix(2);
`ifdef INPUT_PACKER_LAST_CHECK_EN
    send_beats(0, 51, 50, 0);
    chk("early_last_err", {31'd0, err}, 32'd1);
    chk("early_last_m_valid", {31'd0, m_if.valid}, 32'd0);
    @(posedge clk); #1;
    chk("early_last_err_pulse", {31'd0, err}, 32'd0);
    fill_pix(2);
    send_beats(0, NB, NB - 1, 0);
    chk("after_err_m_valid", {31'd0, m_if.valid}, 32'd1);
    chk("after_err_err", {31'd0, err}, 32'd0);
    chk_data("after_err_m_data", m_if.data, model_frame());
    handshake();
`else
    send_beats(0, 51, 50, 0);
    chk("ign_last_err", {31'd0, err}, 32'd0);
    chk("ign_last_m_valid", {31'd0, m_if.valid}, 32'd0);
    send_beats(51, NB, NB - 1, 0);
    chk("ign_last_m_valid_end", {31'd0, m_if.valid}, 32'd1);
    chk_data("ign_last_m_data", m_if.data, model_frame());
    handshake();
`endif

    // Frame counter wrap from 0xFFFF
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    exp_fc = 16'hFFFF;
    chk("wrap_preload", {16'd0, frame_cnt}, 32'h0000_FFFF);
    fill_pix(2);
    send_beats(0, NB, NB - 1, 0);
    chk_data("wrap_m_data", m_if.data, model_frame());
    handshake();
    chk("wrap_zero", {16'd0, frame_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
